// File: rtl/hazard_seq_ctrl.sv
// Pipeline sequencing controller: PC / pipeline-register enables, flushes and bubbles
// for boot, load-use stalls, branches, memory freeze, two-word fetch and interrupt entry.
module hazard_seq_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_two_word,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             intr_req,
  input  logic             intr_en,
  output logic             pc_write,
  output logic             vec_load,
  output logic             vec_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             imm_capture,
  output logic             push_pc,
  output logic             push_flags,
  output logic             intr_ack,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    RUN       = 3'd1,
    IMM       = 3'd2,
    INT_FLUSH = 3'd3,
    INT_PC    = 3'd4,
    INT_FLAGS = 3'd5,
    INT_VEC   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  state_t next_state;
  logic   intr_pend;
  logic   load_use;

  logic pc_write_d, vec_load_d, vec_sel_d, ifid_write_d, ifid_flush_d;
  logic idex_bubble_d, imm_capture_d, push_pc_d, push_flags_d, intr_ack_d;

  assign load_use = ex_mem_read &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= next_state;
    end
  end

  // Pending interrupt latch; a new request in the acknowledge cycle keeps it set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intr_pend <= 1'b0;
    end else begin
      intr_pend <= intr_req | (intr_pend & ~intr_ack_d);
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (!pc_write_d && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  // Next-state and raw control decode
  always_comb begin
    next_state    = state;
    pc_write_d    = 1'b1;
    ifid_write_d  = 1'b1;
    vec_load_d    = 1'b0;
    vec_sel_d     = 1'b0;
    ifid_flush_d  = 1'b0;
    idex_bubble_d = 1'b0;
    imm_capture_d = 1'b0;
    push_pc_d     = 1'b0;
    push_flags_d  = 1'b0;
    intr_ack_d    = 1'b0;
    case (state)
      BOOT: begin
        vec_load_d    = 1'b1;
        ifid_flush_d  = 1'b1;
        idex_bubble_d = 1'b1;
        next_state    = RUN;
      end
      RUN: begin
        if (mem_busy) begin
          pc_write_d    = 1'b0;
          ifid_write_d  = 1'b0;
          idex_bubble_d = 1'b1;
        end else if (branch_taken) begin
          ifid_flush_d  = 1'b1;
          idex_bubble_d = 1'b1;
        end else if (load_use) begin
          pc_write_d    = 1'b0;
          ifid_write_d  = 1'b0;
          idex_bubble_d = 1'b1;
        end else if (intr_pend && intr_en) begin
          pc_write_d = 1'b0;
          next_state = INT_FLUSH;
        end else if (id_two_word) begin
          ifid_write_d  = 1'b0;
          idex_bubble_d = 1'b1;
          next_state    = IMM;
        end else begin
          next_state = RUN;
        end
      end
      IMM: begin
        // Branches and interrupts wait until the immediate word is in hand
        if (mem_busy) begin
          pc_write_d    = 1'b0;
          ifid_write_d  = 1'b0;
          idex_bubble_d = 1'b1;
        end else begin
          imm_capture_d = 1'b1;
          next_state    = RUN;
        end
      end
      INT_FLUSH: begin
        pc_write_d    = 1'b0;
        ifid_flush_d  = 1'b1;
        idex_bubble_d = 1'b1;
        next_state    = INT_PC;
      end
      INT_PC: begin
        push_pc_d     = 1'b1;
        pc_write_d    = 1'b0;
        idex_bubble_d = 1'b1;
        if (mem_busy) begin
          next_state = INT_PC;
        end else begin
          next_state = INT_FLAGS;
        end
      end
      INT_FLAGS: begin
        push_flags_d  = 1'b1;
        pc_write_d    = 1'b0;
        idex_bubble_d = 1'b1;
        if (mem_busy) begin
          next_state = INT_FLAGS;
        end else begin
          next_state = INT_VEC;
        end
      end
      INT_VEC: begin
        vec_load_d   = 1'b1;
        vec_sel_d    = 1'b1;
        ifid_flush_d = 1'b1;
        intr_ack_d   = 1'b1;
        next_state   = RUN;
      end
      default: begin
        next_state = BOOT;
      end
    endcase
  end

  // Reset forces every control line low without waiting for a clock
  assign pc_write    = pc_write_d    & ~reset;
  assign vec_load    = vec_load_d    & ~reset;
  assign vec_sel     = vec_sel_d     & ~reset;
  assign ifid_write  = ifid_write_d  & ~reset;
  assign ifid_flush  = ifid_flush_d  & ~reset;
  assign idex_bubble = idex_bubble_d & ~reset;
  assign imm_capture = imm_capture_d & ~reset;
  assign push_pc     = push_pc_d     & ~reset;
  assign push_flags  = push_flags_d  & ~reset;
  assign intr_ack    = intr_ack_d    & ~reset;

endmodule

// File: tb/tb_hazard_seq_ctrl.sv
// Scoreboard bench for hazard_seq_ctrl: stimulus pushes reference-model expectations,
// a negedge monitor pops and compares them against the DUT every cycle.
module tb_hazard_seq_ctrl;
  localparam int REG_W = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [REG_W-1:0] id_rs = 3'd0, id_rt = 3'd0, ex_rd = 3'd0;
  logic             id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_two_word = 1'b0;
  logic             ex_mem_read = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;
  logic             intr_req = 1'b0, intr_en = 1'b0;
  logic             pc_write, vec_load, vec_sel, ifid_write, ifid_flush, idex_bubble;
  logic             imm_capture, push_pc, push_flags, intr_ack;
  logic [CNT_W-1:0] stall_cnt;
  logic [9:0]       outs;

  always #5 clk = ~clk;

  hazard_seq_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_two_word(id_two_word),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .intr_req(intr_req), .intr_en(intr_en),
    .pc_write(pc_write), .vec_load(vec_load), .vec_sel(vec_sel),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .imm_capture(imm_capture), .push_pc(push_pc), .push_flags(push_flags),
    .intr_ack(intr_ack), .stall_cnt(stall_cnt)
  );

  assign outs = {pc_write, vec_load, vec_sel, ifid_write, ifid_flush,
                 idex_bubble, imm_capture, push_pc, push_flags, intr_ack};

  typedef struct packed {
    logic [9:0]  o;
    logic [15:0] c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: boot flag, immediate-pending flag, interrupt step 0..4, pending latch
  bit          m_boot = 1'b1, m_imm = 1'b0, m_pend = 1'b0;
  int          m_step = 0;
  int unsigned m_cnt = 0;
  bit          n_boot = 1'b1, n_imm = 1'b0, n_pend = 1'b0;
  int          n_step = 0;
  int unsigned n_cnt = 0;

  task automatic model_eval();
    bit pw, vl, vs, iw, fl, bb, ic, pp, pf, ak, lu;
    exp_t e;
    pw = 1'b1; iw = 1'b1;
    vl = 1'b0; vs = 1'b0; fl = 1'b0; bb = 1'b0; ic = 1'b0; pp = 1'b0; pf = 1'b0; ak = 1'b0;
    lu = ex_mem_read && ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (reset) begin
      pw = 1'b0; iw = 1'b0;
      m_boot = 1'b1; m_imm = 1'b0; m_step = 0; m_pend = 1'b0; m_cnt = 0;
      n_boot = 1'b1; n_imm = 1'b0; n_step = 0; n_pend = 1'b0; n_cnt = 0;
    end else begin
      n_boot = m_boot; n_imm = m_imm; n_step = m_step;
      if (m_boot) begin
        vl = 1'b1; fl = 1'b1; bb = 1'b1; n_boot = 1'b0;
      end else if (m_imm) begin
        if (mem_busy) begin pw = 1'b0; iw = 1'b0; bb = 1'b1; end
        else begin ic = 1'b1; n_imm = 1'b0; end
      end else if (m_step == 1) begin
        pw = 1'b0; fl = 1'b1; bb = 1'b1; n_step = 2;
      end else if (m_step == 2 || m_step == 3) begin
        pw = 1'b0; bb = 1'b1;
        if (m_step == 2) pp = 1'b1; else pf = 1'b1;
        if (!mem_busy) n_step = m_step + 1;
      end else if (m_step == 4) begin
        vl = 1'b1; vs = 1'b1; fl = 1'b1; ak = 1'b1; n_step = 0;
      end else if (mem_busy) begin
        pw = 1'b0; iw = 1'b0; bb = 1'b1;
      end else if (branch_taken) begin
        fl = 1'b1; bb = 1'b1;
      end else if (lu) begin
        pw = 1'b0; iw = 1'b0; bb = 1'b1;
      end else if (m_pend && intr_en) begin
        pw = 1'b0; n_step = 1;
      end else if (id_two_word) begin
        iw = 1'b0; bb = 1'b1; n_imm = 1'b1;
      end
      n_pend = intr_req || (m_pend && !ak);
      n_cnt  = (!pw && m_cnt < 32'd65535) ? m_cnt + 32'd1 : m_cnt;
    end
    e.o = {pw, vl, vs, iw, fl, bb, ic, pp, pf, ak};
    e.c = m_cnt[15:0];
    exp_q.push_back(e);
  endtask

  task automatic tick(input bit r, busy, br, ireq, ien, two, mr,
                      input logic [2:0] rd, rs, rt, input bit urs, urt);
    @(posedge clk);
    m_boot = n_boot; m_imm = n_imm; m_step = n_step; m_pend = n_pend; m_cnt = n_cnt;
    #1;
    reset = r; mem_busy = busy; branch_taken = br; intr_req = ireq; intr_en = ien;
    id_two_word = two; ex_mem_read = mr; ex_rd = rd; id_rs = rs; id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt;
    model_eval();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  // Monitor: one expectation per cycle, checked away from the rising edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (outs !== mon_e.o) begin
        errors++;
        $display("FAIL ctrl_outs t=%0t got=%b expected=%b", $time, outs, mon_e.o);
      end
      checks++;
      if (stall_cnt !== mon_e.c) begin
        errors++;
        $display("FAIL stall_cnt t=%0t got=%h expected=%h", $time, stall_cnt, mon_e.c);
      end
    end
  end

  initial begin
    // Reset then boot
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    idle(3);
    // Load-use on rs, then same registers with rs not read
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0);
    idle(2);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 3'd0, 3'd5, 1'b0, 1'b1);
    idle(2);
    // Load-use coinciding with a taken branch
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0);
    idle(2);
    // Interrupt pulse, memory busy for two cycles while pushing the PC
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    idle(2);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    idle(5);
    // Two-word instruction with an interrupt raised during the immediate fetch
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    idle(8);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, 3'($urandom), 3'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom));
    end
    // Reset while pushing the PC: the interrupt must be lost
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    idle(3);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    idle(10);
    // Counter saturation
    for (int i = 0; i < 65541; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_cnt_saturated got=%h expected=ffff", stall_cnt);
    end
    idle(2);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0 pending entries", exp_q.size());
    end
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_seq_ctrl.md
Name: hazard_seq_ctrl

Overview:
- Pipeline sequencing controller for the five-stage core. It sits beside the opcode decoder and drives the PC and pipeline-register enables, flushes and bubbles.
- Handles boot vector load, load-use stalls, taken-branch flush, memory-busy freeze, two-word (immediate) instruction fetch and the interrupt entry sequence.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_W, 3, register-index width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs  in  REG_W  ID-stage source register 1
- id_rt  in  REG_W  ID-stage source register 2
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_two_word  in  1  ID instruction carries a following immediate word
- ex_mem_read  in  1  EX-stage instruction is a load
- ex_rd  in  REG_W  EX-stage destination register
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_busy  in  1  data/instruction memory not ready
- intr_req  in  1  external interrupt request (level)
- intr_en  in  1  interrupts globally enabled
- pc_write  out  1  PC register update enable
- vec_load  out  1  PC loads from vector table
- vec_sel  out  1  vector select: 0 = M[0] reset, 1 = M[1] interrupt
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  IF/ID register cleared to NOP
- idex_bubble  out  1  ID/EX loaded with NOP control
- imm_capture  out  1  ID latches the current fetch word as the immediate
- push_pc  out  1  stack unit pushes the return PC
- push_flags  out  1  stack unit pushes CCR
- intr_ack  out  1  one-cycle interrupt acknowledge
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- State register is updated on the rising edge of clk and cleared asynchronously by reset.
- States: BOOT, RUN, IMM, INT_FLUSH, INT_PC, INT_FLAGS, INT_VEC.
- Outputs are combinational from state and inputs. While reset=1, all outputs are 0 and stall_cnt=0.
- Default outputs (anything not listed for a state/case below): pc_write=1, ifid_write=1, all others 0.
- BOOT (entered after reset):
  - Drives vec_load=1, vec_sel=0, pc_write=1, ifid_flush=1, idex_bubble=1.
  - Next state is RUN; BOOT always lasts exactly one cycle.
- intr_pend latch:
  - Set on any cycle with intr_req=1.
  - Cleared in the cycle intr_ack=1; if intr_req=1 in that same cycle, set wins.
  - Cleared by reset.
- RUN, cases in priority order:
  - mem_busy=1: pc_write=0, ifid_write=0, idex_bubble=1; stay in RUN.
  - branch_taken=1: pc_write=1, ifid_flush=1, idex_bubble=1. The branch-target mux is outside this block. Stay in RUN.
  - Load-use hazard: ex_mem_read and ex_rd matches (id_uses_rs and id_rs) or (id_uses_rt and id_rt). Drive pc_write=0, ifid_write=0, idex_bubble=1; stay in RUN. Each hazard costs exactly one bubble.
  - intr_pend and intr_en: go to INT_FLUSH with pc_write=0.
  - id_two_word=1: pc_write=1, ifid_write=0, idex_bubble=1; go to IMM.
- IMM:
  - If mem_busy=1: freeze (pc_write=0, ifid_write=0, idex_bubble=1) and stay in IMM.
  - Otherwise: imm_capture=1, pc_write=1, ifid_write=1, idex_bubble=0; go to RUN.
  - Interrupts and branches are not accepted in IMM.
- INT_FLUSH: pc_write=0, ifid_flush=1, idex_bubble=1; go to INT_PC.
- INT_PC: push_pc=1, pc_write=0, idex_bubble=1. If mem_busy=1, hold and keep push_pc=1; otherwise go to INT_FLAGS.
- INT_FLAGS: push_flags=1, same hold rule on mem_busy; otherwise go to INT_VEC.
- INT_VEC: vec_load=1, vec_sel=1, pc_write=1, ifid_flush=1, intr_ack=1; go to RUN.
- Interrupt entry is never aborted once started. intr_en dropping mid-sequence is ignored.
- branch_taken outside RUN is ignored; it cannot occur because EX holds bubbles.
- stall_cnt:
  - Increments on every clock edge where pc_write=0 and reset=0.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset asserted mid-sequence: immediate return to all-zero outputs. BOOT follows the deassertion. Any pending interrupt is lost.

Test Plan:
- Release reset → BOOT cycle shows vec_load=1, vec_sel=0, ifid_flush=1; the next cycle is RUN with pc_write=1 and ifid_write=1.
- ex_mem_read=1, ex_rd=3, id_rs=3, id_uses_rs=1 for one cycle → pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle; stall_cnt increments by 1. Repeat with id_uses_rs=0 → no stall.
- Load-use hazard and branch_taken=1 in the same cycle → flush wins: ifid_flush=1, pc_write=1.
- intr_req pulsed for 1 cycle, intr_en=1 → sequence INT_FLUSH, INT_PC, INT_FLAGS, INT_VEC in 4 cycles. intr_ack=1 only in INT_VEC with vec_sel=1. With mem_busy=1 for 2 cycles during INT_PC → push_pc stays high for 3 cycles.
- id_two_word=1 → one cycle with ifid_write=0 and idex_bubble=1, then one cycle with imm_capture=1. intr_req raised during IMM → interrupt entry starts only after returning to RUN.
- Force 2^16+5 cycles with mem_busy=1 → stall_cnt holds at 0xFFFF. Assert reset mid-INT_PC → all outputs are 0 immediately; after deassertion, BOOT runs and intr_ack never asserts.
